// File: rtl/gpr_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : gpr_wr_arb
//  Purpose  : Round-robin arbiter sharing one GPR write port between NREQ
//             requesters. Registers the winning write, flags out-of-range
//             addresses with a sticky error, and counts issued writes.
//  Revision : 1.0  initial release
// ============================================================================
module gpr_wr_arb #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned NREGS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*4-1:0] req_addr,
  input  logic [NREQ*10-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  output logic              write,
  output logic [3:0]        inaddr,
  output logic [9:0]        indata,
  output logic              err,
  output logic [3:0]        err_addr,
  input  logic              err_clr,
  output logic [7:0]        wr_cnt
);

  localparam int unsigned LGW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [LGW-1:0] last_grant_q, last_grant_d;
  logic           write_q, write_d;
  logic [3:0]     inaddr_q, inaddr_d;
  logic [9:0]     indata_q, indata_d;
  logic           err_q, err_d;
  logic [3:0]     err_addr_q, err_addr_d;
  logic [7:0]     wr_cnt_q, wr_cnt_d;

  logic           sel_found;
  logic [LGW-1:0] sel_idx;
  logic [3:0]     sel_addr;
  logic [9:0]     sel_data;
  logic           xfer;
  logic           in_range;

  // Round-robin search: first valid requester after the last winner, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_grant_q) + k) % NREQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = LGW'(idx);
        sel_addr  = req_addr[idx*4 +: 4];
        sel_data  = req_data[idx*10 +: 10];
      end
    end
  end

  // Accept the selected requester unless frozen or held in reset.
  always_comb begin
    req_ready = '0;
    if (rst && !hold && sel_found) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  assign xfer     = |req_ready;
  assign in_range = (32'(sel_addr) < NREGS);

  // Next-state for grant pointer, write port, error flag and write counter.
  always_comb begin
    last_grant_d = last_grant_q;
    write_d      = 1'b0;
    inaddr_d     = inaddr_q;
    indata_d     = indata_q;
    err_d        = err_q;
    err_addr_d   = err_addr_q;
    wr_cnt_d     = wr_cnt_q;

    if (xfer) begin
      last_grant_d = sel_idx;
      if (in_range) begin
        write_d  = 1'b1;
        inaddr_d = sel_addr;
        indata_d = sel_data;
      end
    end

    if (err_clr) begin
      err_d = 1'b0;
    end
    // A new error overrides a same-cycle clear and re-captures the address.
    if (xfer && !in_range) begin
      err_d = 1'b1;
      if (!err_q || err_clr) begin
        err_addr_d = sel_addr;
      end
    end

    if (write_q && (wr_cnt_q != 8'hFF)) begin
      wr_cnt_d = wr_cnt_q + 8'd1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= LGW'(NREQ - 1);
      write_q      <= 1'b0;
      inaddr_q     <= '0;
      indata_q     <= '0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
      wr_cnt_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      inaddr_q     <= inaddr_d;
      indata_q     <= indata_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  assign write    = write_q;
  assign inaddr   = inaddr_q;
  assign indata   = indata_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign wr_cnt   = wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gpr_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpr_wr_arb
//  Purpose  : Self-checking bench for gpr_wr_arb using a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpr_wr_arb;

  localparam int NREQ  = 3;
  localparam int NREGS = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*4-1:0] req_addr  = '0;
  logic [NREQ*10-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              hold = 1'b0;
  logic              write;
  logic [3:0]        inaddr;
  logic [9:0]        indata;
  logic              err;
  logic [3:0]        err_addr;
  logic              err_clr = 1'b0;
  logic [7:0]        wr_cnt;

  gpr_wr_arb #(.NREQ(NREQ), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold), .write(write),
    .inaddr(inaddr), .indata(indata), .err(err), .err_addr(err_addr),
    .err_clr(err_clr), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_last;
  int m_write, m_inaddr, m_indata, m_err, m_err_addr, m_cnt;
  int last_pick;

  function automatic int pick(int last, logic [NREQ-1:0] v, logic h);
    if (h) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = NREQ - 1; m_write = 0; m_inaddr = 0; m_indata = 0;
    m_err = 0; m_err_addr = 0; m_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".write"},    32'(write),    32'(m_write));
    chk({tag, ".inaddr"},   32'(inaddr),   32'(m_inaddr));
    chk({tag, ".indata"},   32'(indata),   32'(m_indata));
    chk({tag, ".err"},      32'(err),      32'(m_err));
    chk({tag, ".err_addr"}, 32'(err_addr), 32'(m_err_addr));
    chk({tag, ".wr_cnt"},   32'(wr_cnt),   32'(m_cnt));
  endtask

  // One clock: apply inputs at negedge, check ready, clock, check registers.
  task automatic step(input string tag, input logic [NREQ-1:0] v,
                      input logic [NREQ*4-1:0] a, input logic [NREQ*10-1:0] d,
                      input logic h, input logic c);
    int g, ga, gd;
    req_valid = v; req_addr = a; req_data = d; hold = h; err_clr = c;
    #1;
    g = pick(m_last, v, h);
    last_pick = g;
    chk({tag, ".ready"}, 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk); #1;
    if (m_write != 0) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    m_write = 0;
    if (c) m_err = 0;
    if (g >= 0) begin
      ga = int'(a[g*4 +: 4]);
      gd = int'(d[g*10 +: 10]);
      m_last = g;
      if (ga < NREGS) begin
        m_write = 1; m_inaddr = ga; m_indata = gd;
      end else begin
        if (m_err == 0 || c) m_err_addr = ga;
        if (!(m_err == 1 && !c)) m_err_addr = m_err_addr;
        m_err = 1;
      end
    end
    chk_regs(tag);
    @(negedge clk);
  endtask

  logic [NREQ-1:0]    rv;
  logic [NREQ*4-1:0]  ra;
  logic [NREQ*10-1:0] rd;

  initial begin
    model_reset();
    // Reset state with requests pending: nothing accepted, outputs cleared
    req_valid = '1; req_addr = {4'd3, 4'd2, 4'd1}; req_data = {10'h3, 10'h2, 10'h1};
    #2;
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk_regs("rst");
    @(negedge clk);
    rst = 1'b1;

    // All valid, addrs 1/2/3: grants rotate 0,1,2,0,...
    for (int n = 0; n < 6; n++)
      step("rr", 3'b111, {4'd3, 4'd2, 4'd1}, {10'h0C3, 10'h0B2, 10'h0A1}, 1'b0, 1'b0);

    // Single requester 1, then idle: write pulses once, address/data hold
    step("r1", 3'b010, {4'd0, 4'd5, 4'd0}, {10'h0, 10'h3FF, 10'h0}, 1'b0, 1'b0);
    step("r1idle", 3'b000, '0, '0, 1'b0, 1'b0);
    step("r1idle2", 3'b000, '0, '0, 1'b0, 1'b0);

    // Hold freezes acceptance for 4 cycles
    for (int n = 0; n < 4; n++)
      step("hold", 3'b001, {4'd0, 4'd0, 4'd7}, {10'h0, 10'h0, 10'h155}, 1'b1, 1'b0);
    step("unhold", 3'b001, {4'd0, 4'd0, 4'd7}, {10'h0, 10'h0, 10'h155}, 1'b0, 1'b0);
    // Hold raised right after a transfer must not cancel the registered write
    step("r0b", 3'b001, {4'd0, 4'd0, 4'd8}, {10'h0, 10'h0, 10'h2AA}, 1'b0, 1'b0);
    step("holdw", 3'b001, {4'd0, 4'd0, 4'd9}, {10'h0, 10'h0, 10'h111}, 1'b1, 1'b0);
    step("idle", 3'b000, '0, '0, 1'b0, 1'b0);

    // Out-of-range addresses: sticky err, first address kept, set beats clear
    step("oor12", 3'b100, {4'd12, 4'd0, 4'd0}, {10'h1, 10'h0, 10'h0}, 1'b0, 1'b0);
    step("oor15", 3'b100, {4'd15, 4'd0, 4'd0}, {10'h2, 10'h0, 10'h0}, 1'b0, 1'b0);
    step("oorclr", 3'b100, {4'd10, 4'd0, 4'd0}, {10'h3, 10'h0, 10'h0}, 1'b0, 1'b1);
    step("clr", 3'b000, '0, '0, 1'b0, 1'b1);
    step("bound9", 3'b001, {4'd0, 4'd0, 4'd9}, {10'h0, 10'h0, 10'h099}, 1'b0, 1'b0);

    // Saturation of the write counter
    for (int n = 0; n < 300; n++)
      step("sat", 3'b001, {4'd0, 4'd0, 4'(n % NREGS)}, {10'h0, 10'h0, 10'(n)}, 1'b0, 1'b0);
    step("satidle", 3'b000, '0, '0, 1'b0, 1'b0);
    chk("sat.final", 32'(wr_cnt), 32'd255);

    // Randomized traffic; a request stays stable until it is accepted
    rv = '0; ra = '0; rd = '0; last_pick = -1;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i] || last_pick == i) begin
          rv[i] = 1'($urandom_range(0, 1));
          ra[i*4 +: 4] = 4'($urandom_range(0, 15));
          rd[i*10 +: 10] = 10'($urandom);
        end
      end
      step("rand", rv, ra, rd, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
    end

    // Mid-stream reset: immediate clear, in-reset edge discarded, 0 first after
    step("pre_rst", 3'b111, {4'd3, 4'd2, 4'd1}, {10'h33, 10'h22, 10'h11}, 1'b0, 1'b0);
    req_valid = '1; hold = 1'b0; err_clr = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst.ready", 32'(req_ready), 32'd0);
    chk_regs("arst");
    @(posedge clk); #1;
    chk("arst2.ready", 32'(req_ready), 32'd0);
    chk_regs("arst2");
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 3'b111, {4'd3, 4'd2, 4'd1}, {10'h33, 10'h22, 10'h11}, 1'b0, 1'b0);
    step("post_rst2", 3'b111, {4'd3, 4'd2, 4'd1}, {10'h33, 10'h22, 10'h11}, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpr_wr_arb.md
GPR_WR_ARB -- requirements
Module: gpr_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of write requesters sharing the single GPR write port.
REQ-002 SHALL have parameter NREGS, default 10: number of implemented GPR entries; valid addresses are 0..NREGS-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-low; asserted when rst=0.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester write request valid.
REQ-006 SHALL have port req_addr  input  NREQ*4  per-requester target register address; requester i uses bits [4i+3:4i].
REQ-007 SHALL have port req_data  input  NREQ*10  per-requester write data; requester i uses bits [10i+9:10i].
REQ-008 SHALL have port req_ready  output  NREQ  per-requester accept, one-hot or zero.
REQ-009 SHALL have port hold  input  1  pipeline freeze; while 1, no request is accepted.
REQ-010 SHALL have port write  output  1  GPR write enable, registered.
REQ-011 SHALL have port inaddr  output  4  GPR write address, registered.
REQ-012 SHALL have port indata  output  10  GPR write data, registered.
REQ-013 SHALL have port err  output  1  sticky out-of-range address flag.
REQ-014 SHALL have port err_addr  output  4  address of the first out-of-range request since the last clear.
REQ-015 SHALL have port err_clr  input  1  clears err.
REQ-016 SHALL have port wr_cnt  output  8  count of GPR writes issued, saturating.

Function
REQ-017 SHALL grant at most one requester per cycle, round-robin: the search starts at (last_grant+1) mod NREQ and takes the first valid requester in ascending-wrap order.
REQ-018 SHALL drive req_ready[i] combinationally high only when hold=0, req_valid[i]=1 and i is the selected requester; a transfer occurs when valid and ready are both high.
REQ-019 SHALL update last_grant only on a transfer; an idle or held cycle leaves it unchanged.
REQ-020 SHALL assert write exactly one cycle after a transfer with an in-range address (req_addr < NREGS), for one cycle per transfer, carrying that requester's addr and data on inaddr/indata.
REQ-021 SHALL sustain back-to-back transfers, one write per cycle, with 1-cycle latency and no bubbles.
REQ-022 SHALL hold inaddr/indata at their last values while write=0.
REQ-023 SHALL accept (ready=1) a request with address >= NREGS but SHALL NOT assert write for it; SHALL set err and, if err was 0, capture err_addr.
REQ-024 SHALL clear err on err_clr=1; when an error and err_clr occur in the same cycle, set wins and err_addr captures the new address.
REQ-025 SHALL increment wr_cnt on every cycle write=1, saturating at 255.
REQ-026 hold=1 SHALL NOT cancel a write already registered for the following cycle.
REQ-027 Requesters SHALL hold valid, addr and data stable until ready; the block is not required to handle withdrawal.

Reset
REQ-028 On rst=0, asynchronously: write=0, inaddr=0, indata=0, err=0, err_addr=0, wr_cnt=0, last_grant=NREQ-1 (requester 0 has first priority); req_ready=0 while rst=0.
REQ-029 A transfer accepted in the cycle rst asserts SHALL be discarded; no write issues after release.
REQ-030 After rst releases, the first rising edge SHALL be able to accept a transfer.

Verification
REQ-031 All 3 valid continuously, in-range addrs 1/2/3, hold=0 -> grants 0,1,2,0,... one per cycle; write=1 every cycle from cycle 2; wr_cnt increments each cycle.
REQ-032 Req1 only, addr=5 data=0x3FF -> ready[1]=1 same cycle; next cycle write=1, inaddr=5, indata=0x3FF; following cycle write=0, inaddr/indata hold.
REQ-033 Req0 valid, hold=1 for 4 cycles then 0 -> ready=0 and write=0 during hold; ready on first unheld cycle; write the cycle after.
REQ-034 Req2 addr=12 -> ready[2]=1, write stays 0, err=1, err_addr=12; then addr=15 -> err_addr stays 12; err_clr with concurrent addr=10 -> err=1, err_addr=10.
REQ-035 300 in-range writes -> wr_cnt=255 and holds.
REQ-036 rst=0 mid-stream with all valid -> all outputs at reset values immediately; after release, requester 0 is granted first.
